// File: rtl/key_gesture_pkg.sv
// Shared state encoding and ms-to-cycle helper for the key gesture detector.
// ST_LONG_HELD exists only when KEY_GESTURE_LONG_PRESS_EN is defined.
package key_gesture_pkg;

`ifdef KEY_GESTURE_LONG_PRESS_EN
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_GAP       = 2'd2,
    ST_LONG_HELD = 2'd3
  } kg_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_GAP     = 2'd2
  } kg_state_e;
`endif

  function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 32'd1000) * ms;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel front end: 2-flop synchroniser plus a stable-time debounce counter.
// press_o/release_o are high in the cycle before level_o changes.
module key_debounce #(
  parameter int unsigned DB_CYC = 20
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned DB_W = $clog2(DB_CYC) + 1;

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic            level_d;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;
  logic            differ;
  logic            flip;

  assign differ = (sync2_q != level_q);
  // The terminal differing cycle flips the level instead of advancing the counter.
  assign flip   = differ && (cnt_q >= DB_W'(DB_CYC - 1));

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (flip) begin
      level_d = ~level_q;
    end else if (differ) begin
      cnt_d = (cnt_q != '1) ? cnt_q + DB_W'(1) : cnt_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = flip & level_q;
  assign release_o = flip & ~level_q;

endmodule

// File: rtl/key_gesture_det.sv
// Multi-key gesture detector: per-key debounce feeding a click/gap FSM per channel.
// Long-press detection is built only when KEY_GESTURE_LONG_PRESS_EN is defined.
module key_gesture_det
  import key_gesture_pkg::*;
#(
  parameter int unsigned  NUM_KEYS    = 4,
  parameter int unsigned  CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned  DEBOUNCE_MS = 20,
  parameter int unsigned  GAP_MS      = 300,
  parameter int unsigned  LONG_MS     = 1000,
  parameter int unsigned  MAX_CLICKS  = 3,
  localparam int unsigned CW          = $clog2(MAX_CLICKS + 1)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [NUM_KEYS-1:0]    key_in,
  output logic [NUM_KEYS-1:0]    key_level,
  output logic [NUM_KEYS-1:0]    evt_valid,
  output logic [NUM_KEYS*CW-1:0] evt_clicks,
  output logic [NUM_KEYS-1:0]    evt_long
);

  localparam int unsigned DB_CYC  = ms_to_cyc(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int unsigned GAP_CYC = ms_to_cyc(CLK_FREQ_HZ, GAP_MS);
  localparam int unsigned GAP_W   = $clog2(GAP_CYC) + 1;
`ifdef KEY_GESTURE_LONG_PRESS_EN
  localparam int unsigned LONG_CYC = ms_to_cyc(CLK_FREQ_HZ, LONG_MS);
  localparam int unsigned LONG_W   = $clog2(LONG_CYC) + 1;
`endif

  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rel;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
    kg_state_e        state_q;
    logic [CW-1:0]    clicks_q;
    logic [GAP_W-1:0] gap_q;
    logic             ev_q;
    logic [CW-1:0]    ev_clicks_q;
    logic             ev_long_q;
`ifdef KEY_GESTURE_LONG_PRESS_EN
    logic [LONG_W-1:0] hold_q;
`endif

    key_debounce #(
      .DB_CYC(DB_CYC)
    ) u_db (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .key_i    (key_in[gi]),
      .level_o  (key_level[gi]),
      .press_o  (press[gi]),
      .release_o(rel[gi])
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state_q     <= ST_IDLE;
        clicks_q    <= '0;
        gap_q       <= '0;
        ev_q        <= 1'b0;
        ev_clicks_q <= '0;
        ev_long_q   <= 1'b0;
`ifdef KEY_GESTURE_LONG_PRESS_EN
        hold_q      <= '0;
`endif
      end else begin
        ev_q <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (press[gi]) begin
              state_q  <= ST_PRESSED;
              clicks_q <= CW'(1);
`ifdef KEY_GESTURE_LONG_PRESS_EN
              hold_q   <= '0;
`endif
            end
          end
          ST_PRESSED: begin
            if (rel[gi]) begin
              if (clicks_q == CW'(MAX_CLICKS)) begin
                ev_q        <= 1'b1;
                ev_clicks_q <= clicks_q;
                ev_long_q   <= 1'b0;
                state_q     <= ST_IDLE;
              end else begin
                state_q <= ST_GAP;
                gap_q   <= '0;
              end
            end
`ifdef KEY_GESTURE_LONG_PRESS_EN
            else if (clicks_q == CW'(1) && hold_q >= LONG_W'(LONG_CYC - 1)) begin
              ev_q        <= 1'b1;
              ev_clicks_q <= CW'(1);
              ev_long_q   <= 1'b1;
              state_q     <= ST_LONG_HELD;
            end else if (hold_q != '1) begin
              hold_q <= hold_q + LONG_W'(1);
            end
`endif
          end
          ST_GAP: begin
            // A press landing on the expiry cycle continues the gesture.
            if (press[gi]) begin
              state_q  <= ST_PRESSED;
              clicks_q <= clicks_q + CW'(1);
`ifdef KEY_GESTURE_LONG_PRESS_EN
              hold_q   <= '0;
`endif
            end else if (gap_q >= GAP_W'(GAP_CYC - 1)) begin
              ev_q        <= 1'b1;
              ev_clicks_q <= clicks_q;
              ev_long_q   <= 1'b0;
              state_q     <= ST_IDLE;
            end else if (gap_q != '1) begin
              gap_q <= gap_q + GAP_W'(1);
            end
          end
`ifdef KEY_GESTURE_LONG_PRESS_EN
          ST_LONG_HELD: begin
            if (rel[gi]) begin
              state_q <= ST_IDLE;
            end
          end
`endif
          default: state_q <= ST_IDLE;
        endcase
      end
    end

    assign evt_valid[gi]            = ev_q;
    assign evt_clicks[gi*CW +: CW]  = ev_clicks_q;
    assign evt_long[gi]             = ev_long_q;
  end

endmodule

// File: tb/tb_key_gesture_det.sv
// Directed bench for key_gesture_det: table of single-channel gestures plus
// hand sequences for glitches, simultaneous events and reset behaviour.
module tb_key_gesture_det;

  localparam int NK = 4;
  localparam int CW = 2;

  logic             sys_clk   = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic [NK-1:0]    key_in    = '1;
  logic [NK-1:0]    key_level;
  logic [NK-1:0]    evt_valid;
  logic [NK*CW-1:0] evt_clicks;
  logic [NK-1:0]    evt_long;

  key_gesture_det #(
    .NUM_KEYS   (4),
    .CLK_FREQ_HZ(1000),
    .DEBOUNCE_MS(20),
    .GAP_MS     (300),
    .LONG_MS    (1000),
    .MAX_CLICKS (3)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .key_level (key_level),
    .evt_valid (evt_valid),
    .evt_clicks(evt_clicks),
    .evt_long  (evt_long)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Event / level-edge monitor, sampled on the falling edge.
  int            ev_cnt   [NK];
  int            ev_cyc   [NK];
  int            ev_clk   [NK];
  int            ev_lng   [NK];
  int            fall_cyc [NK];
  int            rise_cyc [NK];
  logic [NK-1:0] lvl_prev = '1;
  logic [NK-1:0] v_prev   = '0;
  int            consec   = 0;

  always @(negedge sys_clk) begin
    for (int i = 0; i < NK; i++) begin
      if (evt_valid[i]) begin
        ev_cnt[i] <= ev_cnt[i] + 1;
        ev_cyc[i] <= cyc;
        ev_clk[i] <= int'(evt_clicks[i*CW +: CW]);
        ev_lng[i] <= int'(evt_long[i]);
        $display("EVT ch=%0d cyc=%0d clicks=%0d long=%0b", i, cyc, evt_clicks[i*CW +: CW], evt_long[i]);
      end
      if (lvl_prev[i] && !key_level[i]) fall_cyc[i] <= cyc;
      if (!lvl_prev[i] && key_level[i]) rise_cyc[i] <= cyc;
    end
    if ((evt_valid & v_prev) != '0) consec <= consec + 1;
    v_prev   <= evt_valid;
    lvl_prev <= key_level;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_event(input int ch, input int base, input int limit);
    int w;
    w = 0;
    while (ev_cnt[ch] == base && w < limit) begin
      cycles(1);
      w++;
    end
  endtask

  typedef struct {
    int ch;
    int n;
    int hold;
    int gap;
    int exp_clicks;
    int exp_long;
    int exp_lat;   // long: from debounced fall; otherwise from last debounced rise
  } vec_t;

  vec_t vecs [4];

  initial begin
    int base [NK];
    int others;
    int t_edge;
    int t_rel;
    int seen;
    int lat;

    vecs[0] = '{0, 1, 100, 0,   1, 0, 300};
    vecs[1] = '{1, 2, 100, 150, 2, 0, 300};
    // Third release ends the gesture at once: event on the edge key_level rises.
    vecs[2] = '{2, 3, 100, 100, 3, 0, 0};
`ifdef KEY_GESTURE_LONG_PRESS_EN
    vecs[3] = '{3, 1, 1500, 0,  1, 1, 1000};
`else
    vecs[3] = '{3, 1, 1500, 0,  1, 0, 300};
`endif

    // Reset state.
    cycles(5);
    chk("rst_key_level", 32'(key_level), 32'hF);
    chk("rst_evt_valid", 32'(evt_valid), 32'h0);
    chk("rst_evt_clicks", 32'(evt_clicks), 32'h0);
    chk("rst_evt_long", 32'(evt_long), 32'h0);
    sys_rst_n = 1'b1;
    cycles(5);

    // Table-driven single-channel gestures.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < NK; i++) base[i] = ev_cnt[i];
      t_edge = 0;
      t_rel  = 0;
      for (int p = 0; p < vecs[v].n; p++) begin
        key_in[vecs[v].ch] = 1'b0;
        if (p == 0) t_edge = cyc;
        cycles(vecs[v].hold);
        key_in[vecs[v].ch] = 1'b1;
        t_rel = cyc;
        if (p < vecs[v].n - 1) cycles(vecs[v].gap);
      end
      wait_event(vecs[v].ch, base[vecs[v].ch], 2500);
      cycles(400);
      others = 0;
      for (int i = 0; i < NK; i++) if (i != vecs[v].ch) others += ev_cnt[i] - base[i];
      chk($sformatf("v%0d_event_count", v), 32'(ev_cnt[vecs[v].ch] - base[vecs[v].ch]), 32'd1);
      chk($sformatf("v%0d_other_events", v), 32'(others), 32'd0);
      chk($sformatf("v%0d_clicks", v), 32'(ev_clk[vecs[v].ch]), 32'(vecs[v].exp_clicks));
      chk($sformatf("v%0d_long", v), 32'(ev_lng[vecs[v].ch]), 32'(vecs[v].exp_long));
      lat = (vecs[v].exp_long != 0) ? ev_cyc[vecs[v].ch] - fall_cyc[vecs[v].ch]
                                    : ev_cyc[vecs[v].ch] - rise_cyc[vecs[v].ch];
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      chk($sformatf("v%0d_rise_delay", v), 32'(rise_cyc[vecs[v].ch] - t_rel), 32'd22);
      if (vecs[v].n == 1)
        chk($sformatf("v%0d_fall_delay", v), 32'(fall_cyc[vecs[v].ch] - t_edge), 32'd22);
    end

    // 10-cycle glitch on an idle key: no level change, no event.
    base[0] = ev_cnt[0];
    key_in[0] = 1'b0;
    cycles(10);
    key_in[0] = 1'b1;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      cycles(1);
      if (key_level[0] == 1'b0) seen++;
    end
    cycles(400);
    chk("glitch_idle_level_low", 32'(seen), 32'd0);
    chk("glitch_idle_events", 32'(ev_cnt[0] - base[0]), 32'd0);

    // 10-cycle release glitch inside a press: level stays low, single click.
    base[1] = ev_cnt[1];
    key_in[1] = 1'b0;
    cycles(100);
    key_in[1] = 1'b1;
    cycles(10);
    key_in[1] = 1'b0;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      cycles(1);
      if (key_level[1] == 1'b1) seen++;
    end
    cycles(40);
    key_in[1] = 1'b1;
    wait_event(1, base[1], 1000);
    cycles(50);
    chk("glitch_press_level_high", 32'(seen), 32'd0);
    chk("glitch_press_events", 32'(ev_cnt[1] - base[1]), 32'd1);
    chk("glitch_press_clicks", 32'(ev_clk[1]), 32'd1);

    // Keys 0 and 1 clicked together: events in the same cycle.
    base[0] = ev_cnt[0];
    base[1] = ev_cnt[1];
    key_in[1:0] = 2'b00;
    cycles(100);
    key_in[1:0] = 2'b11;
    wait_event(0, base[0], 1000);
    cycles(50);
    chk("simul_ch0_events", 32'(ev_cnt[0] - base[0]), 32'd1);
    chk("simul_ch1_events", 32'(ev_cnt[1] - base[1]), 32'd1);
    chk("simul_same_cycle", 32'(ev_cyc[1] - ev_cyc[0]), 32'd0);

    // Reset pulsed during a gap: gesture discarded, outputs at reset values.
    base[2] = ev_cnt[2];
    key_in[2] = 1'b0;
    cycles(100);
    key_in[2] = 1'b1;
    cycles(100);
    sys_rst_n = 1'b0;
    cycles(2);
    chk("gap_rst_key_level", 32'(key_level), 32'hF);
    chk("gap_rst_evt_valid", 32'(evt_valid), 32'h0);
    chk("gap_rst_evt_clicks", 32'(evt_clicks), 32'h0);
    chk("gap_rst_evt_long", 32'(evt_long), 32'h0);
    sys_rst_n = 1'b1;
    cycles(500);
    chk("gap_rst_no_event", 32'(ev_cnt[2] - base[2]), 32'd0);

    // Reset while a key is held: it is re-debounced as a fresh press.
    base[3] = ev_cnt[3];
    key_in[3] = 1'b0;
    cycles(100);
    sys_rst_n = 1'b0;
    cycles(3);
    chk("held_rst_level", 32'(key_level[3]), 32'd1);
    sys_rst_n = 1'b1;
    t_edge = cyc;
    cycles(60);
    chk("held_rst_fall_delay", 32'(fall_cyc[3] - t_edge), 32'd22);
    key_in[3] = 1'b1;
    wait_event(3, base[3], 1000);
    cycles(50);
    chk("held_rst_events", 32'(ev_cnt[3] - base[3]), 32'd1);
    chk("held_rst_clicks", 32'(ev_clk[3]), 32'd1);
    chk("held_rst_long", 32'(ev_lng[3]), 32'd0);

    chk("no_back_to_back_valid", 32'(consec), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
